// File: rtl/tone_bank_sweep.sv
// tone_bank_sweep: multi-channel square-wave tone generator.
// Each channel runs off, at a fixed half-period, or in a linear sweep between
// a programmed start and end half-period. Channels are programmed one per cycle
// through a valid/ready write port. All channels are merged into one mixed pin.
// Optional macro TONE_BANK_MIX_PWM_EN: mix_out becomes a first-order
// sigma-delta of the number of high tone bits instead of their XOR.
module tone_bank_sweep #(
  parameter int CHANNELS    = 4,
  parameter int CH_IDX_W    = 2,
  parameter int PERIOD_W    = 16,
  parameter int SWEEP_DIV_W = 9
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CH_IDX_W-1:0]  wr_channel,
  input  logic [1:0]           wr_mode,
  input  logic [PERIOD_W-1:0]  wr_start,
  input  logic [PERIOD_W-1:0]  wr_end,
  output logic [CHANNELS-1:0]  tone_out,
  output logic                 mix_out
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_SWEEP = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  // Handshake: a write transfers on a rising clock edge where wr_valid && wr_ready
  // are both high. wr_ready is low in reset, rises on the first edge after release
  // and then stays high, so at most one write is taken per cycle.
  logic                   accept;
  logic [SWEEP_DIV_W-1:0] prescaler;
  logic                   sweep_tick;
  logic [PERIOD_W-1:0]    start_clamped;
  logic [PERIOD_W-1:0]    end_clamped;

  assign accept     = wr_valid && wr_ready;
  assign sweep_tick = &prescaler;

  // A zero half-period would never toggle sensibly, so it is treated as 1.
  assign start_clamped = (wr_start == '0) ? PERIOD_W'(1) : wr_start;
  assign end_clamped   = (wr_end   == '0) ? PERIOD_W'(1) : wr_end;

  // Write port becomes ready one edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wr_ready <= 1'b0;
    else          wr_ready <= 1'b1;
  end

  // Free-running prescaler; the sweep tick is the cycle it reads all ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prescaler <= '0;
    else          prescaler <= prescaler + SWEEP_DIV_W'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [CH_IDX_W-1:0] CH_ID = CH_IDX_W'(i);

    mode_t               mode;
    logic [PERIOD_W-1:0] start_hp;
    logic [PERIOD_W-1:0] end_hp;
    logic [PERIOD_W-1:0] half_period;
    logic [PERIOD_W-1:0] counter;
    logic [PERIOD_W-1:0] sweep_hp;
    logic                tone;
    logic                hit;
    logic                running;

    assign hit     = accept && (wr_channel == CH_ID);
    assign running = (mode == MODE_FIXED) || (mode == MODE_SWEEP);

    // Next half-period on a sweep tick: wrap at the end, otherwise step toward it.
    always_comb begin
      sweep_hp = half_period;
      if (half_period == end_hp)  sweep_hp = start_hp;
      else if (start_hp < end_hp) sweep_hp = half_period + PERIOD_W'(1);
      else if (start_hp > end_hp) sweep_hp = half_period - PERIOD_W'(1);
    end

    // Channel state: a write restarts the phase and wins over a same-cycle tick;
    // the >= compare toggles at once if a sweep shrinks the period below the count.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        mode        <= MODE_OFF;
        start_hp    <= '0;
        end_hp      <= '0;
        half_period <= '0;
        counter     <= '0;
        tone        <= 1'b0;
      end else if (hit) begin
        mode        <= mode_t'(wr_mode);
        start_hp    <= start_clamped;
        end_hp      <= end_clamped;
        half_period <= start_clamped;
        counter     <= '0;
        tone        <= 1'b0;
      end else if (running) begin
        if (counter >= half_period - PERIOD_W'(1)) begin
          tone    <= ~tone;
          counter <= '0;
        end else begin
          counter <= counter + PERIOD_W'(1);
        end
        if ((mode == MODE_SWEEP) && sweep_tick) half_period <= sweep_hp;
      end else begin
        counter <= '0;
        tone    <= 1'b0;
      end
    end

    assign tone_out[i] = tone;
  end

`ifdef TONE_BANK_MIX_PWM_EN
  localparam int ACC_W = CH_IDX_W + 1;
  localparam logic [ACC_W:0] CH_CNT = (ACC_W + 1)'(CHANNELS);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] pop;
  logic [ACC_W:0]   sum;

  // Number of channels currently high.
  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) pop = pop + ACC_W'(tone_out[i]);
  end

  assign sum = {1'b0, acc} + {1'b0, pop};

  // First-order sigma-delta: emit a 1 each time the accumulated count crosses CHANNELS.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      mix_out <= 1'b0;
    end else if (sum >= CH_CNT) begin
      acc     <= ACC_W'(sum - CH_CNT);
      mix_out <= 1'b1;
    end else begin
      acc     <= sum[ACC_W-1:0];
      mix_out <= 1'b0;
    end
  end
`else
  // Mixed output is the registered XOR of all channel tones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) mix_out <= 1'b0;
    else          mix_out <= ^tone_out;
  end
`endif

endmodule

// File: doc/tone_bank_sweep.md
Name: tone_bank_sweep

Overview:
- Multi-channel square-wave tone generator; successor to the single fixed-frequency note generator.
- Each channel's half-period is runtime-programmable through a valid/ready write port. Channels run in off, fixed or linear-sweep mode.
- Drives per-channel tone pins plus one mixed audio pin toward GPIO/speaker logic.

Parameters:
- CHANNELS, 4, number of tone channels (1..16).
- CH_IDX_W, 2, width of channel index; must satisfy 2**CH_IDX_W >= CHANNELS.
- PERIOD_W, 16, width of half-period, in clock cycles.
- SWEEP_DIV_W, 9, sweep tick every 2**SWEEP_DIV_W clocks.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write port ready
- wr_channel  in  CH_IDX_W  target channel
- wr_mode  in  2  mode: 0 off, 1 fixed, 2 sweep, 3 reserved (treated as off)
- wr_start  in  PERIOD_W  initial half-period
- wr_end  in  PERIOD_W  sweep end half-period (ignored unless sweep mode)
- tone_out  out  CHANNELS  per-channel square wave
- mix_out  out  1  mixed output

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clock.
- Reset values:
  - tone_out=0, mix_out=0, wr_ready=0.
  - All channel modes off; half_period, start, end, counters and prescaler all 0.
- wr_ready rises on the first clock edge after reset release and then stays 1; a single write is accepted per cycle.
- Write accept condition: wr_valid && wr_ready.
- On accept, the channel registers update at that edge:
  - mode, start, end and half_period take the written values; half_period = start.
  - Counter cleared and tone bit cleared (phase restart).
  - wr_start or wr_end of 0 is clamped to 1.
- Accepts with wr_channel >= CHANNELS are acknowledged but have no effect.
- Per channel, mode off/reserved: counter held 0, tone 0.
- Per channel, mode fixed/sweep, each clock:
  - If counter >= half_period-1: toggle tone, counter <= 0.
  - Else: counter <= counter+1.
  - The >= comparison ensures an immediate toggle when sweep shrinks half_period below the current count.
- Output period = 2*half_period clocks; first toggle occurs half_period cycles after the accept edge.
- Prescaler: SWEEP_DIV_W-bit free-running counter; sweep tick asserts for one cycle when the prescaler is all ones.
- On a tick, each sweep-mode channel updates half_period:
  - half_period == end: wrap to start.
  - start < end: increment.
  - start > end: decrement.
  - start == end: hold.
- The counter is not cleared by a sweep step.
- A write and a tick on the same channel in the same cycle: the write wins and the tick is ignored for that channel.
- Arithmetic is unsigned PERIOD_W-bit; no overflow is possible because the sweep stays within [min(start,end), max(start,end)].
- Reset asserted mid-operation returns everything to reset values immediately; no partial state survives.
- Latency: tone_out is registered directly from toggle flops; mix_out is registered one cycle after tone_out.

Optional Feature:
- Macro: TONE_BANK_MIX_PWM_EN.
- Defined: mix_out is a first-order sigma-delta of the number of high tone_out bits.
  - Accumulator width CH_IDX_W+1; each cycle acc <= acc + popcount(tone_out).
  - If the sum >= CHANNELS: subtract CHANNELS and mix_out=1; else mix_out=0.
  - Output duty therefore equals the fraction of active-high channels.
- Undefined: mix_out is the registered XOR of all tone_out bits; no accumulator is instantiated.

Test Plan (CHANNELS=4, PERIOD_W=16, SWEEP_DIV_W=4):
- Write ch0 fixed, start=3, one cycle after reset release -> tone_out[0] rises 3 cycles after accept, then toggles every 3 cycles (period 6); other channels stay 0.
- Write ch2 fixed, start=0 -> clamped to 1; tone_out[2] toggles every cycle. Rewrite ch2 with mode=0 -> tone_out[2]=0 on the next cycle and stays low.
- Write ch1 sweep, start=4, end=6 -> at successive 16-cycle ticks half_period steps 4→5→6→4. Also check start=6, end=4 -> 6→5→4→6.
- Sweep ch1 start=10, end=2 with counter at 8 when a tick lowers half_period to 9 -> toggle on that cycle via the >= rule, no missed edge. Write to ch1 on a tick cycle -> written start is loaded and the tick step is discarded.
- Write wr_channel=5 (CH_IDX_W=3 build) -> accepted (wr_ready=1), no tone_out change. Assert reset_n=0 mid-sweep -> all outputs 0 asynchronously, wr_ready=0 until the first edge after release.
- Mix check, ch0 and ch1 fixed at start=2, others off:
  - With TONE_BANK_MIX_PWM_EN: mix_out duty over 400 cycles = (average high count)/4 ±1 cycle.
  - Without it: mix_out = previous-cycle XOR of tone_out.
